// File: rtl/cpu_pkg.sv
// Shared definitions for the front end: next-PC select codes, fetch FSM states
// and the bubble instruction placed in IF/ID.
package cpu_pkg;

    localparam logic [1:0] BR_PC4    = 2'b00;
    localparam logic [1:0] BR_BRANCH = 2'b01;
    localparam logic [1:0] BR_JALR   = 2'b10;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DROP = 2'b10,
        HOLD = 2'b11
    } fetch_state_t;

    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == BR_BRANCH) || (sel == BR_JALR);
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection; redirect targets are forced word-aligned.
module next_pc_mux
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      br_sel,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] next_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    always_comb begin
        case (br_sel)
            BR_BRANCH: next_pc = br_target & ALIGN_MASK;
            BR_JALR:   next_pc = jalr_target & ALIGN_MASK;
            default:   next_pc = pc + XLEN'(4);
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack fetch handshake, fills
// IF/ID, absorbs stalls in a one-entry skid buffer and squashes on redirects.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      br_sel,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic            flush
);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] drop_addr_reg, drop_addr_next;
    logic [XLEN-1:0] skid_pc_reg, skid_pc_next;
    logic [31:0]     skid_instr_reg, skid_instr_next;
    logic            ifid_valid_reg, ifid_valid_next;
    logic [XLEN-1:0] ifid_pc_reg, ifid_pc_next;
    logic [31:0]     ifid_instr_reg, ifid_instr_next;
    logic            flush_reg, flush_next;

    logic            redirect;
    logic [1:0]      sel_eff;
    logic [XLEN-1:0] next_pc;

    // While stalled br_sel is ignored, so the mux yields pc+4 for skid captures.
    assign redirect = !stall && is_redirect(br_sel);
    assign sel_eff  = stall ? BR_PC4 : br_sel;

    next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
        .br_sel      (sel_eff),
        .pc          (pc_reg),
        .br_target   (br_target),
        .jalr_target (jalr_target),
        .next_pc     (next_pc)
    );

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drop_addr_next  = drop_addr_reg;
        skid_pc_next    = skid_pc_reg;
        skid_instr_next = skid_instr_reg;
        ifid_valid_next = ifid_valid_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;
        flush_next      = 1'b0;
        imem_req        = 1'b0;
        imem_addr       = pc_reg;

        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end

            REQ: begin
                imem_req = 1'b1;
                if (stall) begin
                    if (imem_ack) begin
                        skid_pc_next    = pc_reg;
                        skid_instr_next = imem_rdata;
                        pc_next         = next_pc;
                        state_next      = HOLD;
                    end
                end else if (redirect) begin
                    pc_next         = next_pc;
                    ifid_valid_next = 1'b0;
                    ifid_instr_next = NOP_INSTR;
                    flush_next      = 1'b1;
                    // An unacked request cannot be withdrawn; its data is dropped later.
                    if (!imem_ack) begin
                        drop_addr_next = pc_reg;
                        state_next     = DROP;
                    end
                end else if (imem_ack) begin
                    ifid_valid_next = 1'b1;
                    ifid_pc_next    = pc_reg;
                    ifid_instr_next = imem_rdata;
                    pc_next         = next_pc;
                end else begin
                    ifid_valid_next = 1'b0;
                    ifid_instr_next = NOP_INSTR;
                end
            end

            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_reg;
                if (redirect) begin
                    pc_next = next_pc;
                end
                if (imem_ack) begin
                    state_next = REQ;
                end
            end

            HOLD: begin
                if (!stall) begin
                    state_next = REQ;
                    if (redirect) begin
                        pc_next         = next_pc;
                        ifid_valid_next = 1'b0;
                        ifid_instr_next = NOP_INSTR;
                        flush_next      = 1'b1;
                    end else begin
                        ifid_valid_next = 1'b1;
                        ifid_pc_next    = skid_pc_reg;
                        ifid_instr_next = skid_instr_reg;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            drop_addr_reg  <= RESET_PC;
            skid_pc_reg    <= '0;
            skid_instr_reg <= NOP_INSTR;
            ifid_valid_reg <= 1'b0;
            ifid_pc_reg    <= '0;
            ifid_instr_reg <= NOP_INSTR;
            flush_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drop_addr_reg  <= drop_addr_next;
            skid_pc_reg    <= skid_pc_next;
            skid_instr_reg <= skid_instr_next;
            ifid_valid_reg <= ifid_valid_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
            flush_reg      <= flush_next;
        end
    end

    assign ifid_valid = ifid_valid_reg;
    assign ifid_pc    = ifid_pc_reg;
    assign ifid_instr = ifid_instr_reg;
    assign flush      = flush_reg;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch stage that consumes the branch controller's br_sel and owns the program counter.
- Selects the next PC and issues requests over a req/ack instruction-memory handshake.
- Delivers fetched instructions into the IF/ID pipeline register.
- Handles hazard-unit stalls with a one-entry skid buffer.
- On a redirect, flushes IF/ID and discards any in-flight fetch.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID when invalid (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
br_sel  input  2  next-PC select: 00 PC+4, 01 branch/jal target, 10 jalr target, 11 treated as 00
br_target  input  XLEN  PC-relative target from ID
jalr_target  input  XLEN  register-relative target from ID
stall  input  1  hazard-unit stall; freezes PC and IF/ID
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address; stable while imem_req=1 and no ack
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
ifid_valid  output  1  IF/ID holds a live instruction
ifid_pc  output  XLEN  PC of the IF/ID instruction
ifid_instr  output  32  IF/ID instruction (NOP_INSTR when invalid)
flush  output  1  one-cycle pulse on redirect

Behaviour:
Reset (rst=0, asynchronous)
- pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC.
- ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, flush=0, skid buffer empty.

States: IDLE, REQ, DROP, HOLD.

IDLE
- First clock after reset release: go to REQ. imem_req=1, imem_addr=pc.

REQ
- imem_req=1, imem_addr=pc. Address is held until ack.
- ack, no stall, no redirect: IF/ID <= {1, pc, imem_rdata}; pc <= pc+4; stay in REQ. Throughput is 1 instruction per cycle with zero-wait memory.
- No ack: IF/ID keeps its contents if stall=1, otherwise ifid_valid <= 0.

Redirect
- Condition: br_sel is 01 or 10 AND stall=0.
- pc <= target. jalr_target has bits [1:0] forced to 0; br_target has bit [1:0] forced to 0.
- ifid_valid <= 0, ifid_instr <= NOP_INSTR. flush=1 for exactly this cycle (registered, visible next cycle).
- ack in the same cycle: rdata discarded; stay in REQ with the new pc.
- Fetch outstanding without ack: go to DROP.

DROP
- imem_req stays 1 with the old address, because a request cannot be aborted.
- On ack: discard rdata, go to REQ with the redirected pc.
- A second redirect while in DROP only updates pc.

Stall
- stall=1: pc and IF/ID are frozen and br_sel is ignored. The hazard unit re-presents the branch once the stall drops.
- ack while stall=1 in REQ: capture {pc, rdata} into the skid buffer; pc <= pc+4; go to HOLD; imem_req=0.

HOLD
- imem_req=0.
- stall drops with no redirect: IF/ID <= skid buffer (valid=1); skid emptied; go to REQ.
- stall drops with a redirect in the same cycle: redirect wins, skid discarded, flush pulses, go to REQ with the target.

Arithmetic and mid-operation reset
- pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- Reset mid-operation aborts any fetch; the next ack before the first req is ignored.

Decomposition:
Shared package (cpu_pkg)
- BR_PC4=2'b00, BR_BRANCH=2'b01, BR_JALR=2'b10.
- fetch state enum {IDLE, REQ, DROP, HOLD}.
- NOP_INSTR constant.

Sub-module next_pc_mux (combinational)
- Inputs: br_sel, pc, br_target, jalr_target.
- Output: aligned next PC.
- Everything else stays in pc_fetch_unit.

Test Plan:
1. Reset release, ack every cycle, br_sel=00 -> imem_addr 0,4,8,C on consecutive cycles; ifid_pc follows one cycle behind; ifid_valid=1 from cycle 2.
2. br_sel=01, br_target=0x100, ack same cycle -> flush=1 for one cycle, ifid_valid=0, next imem_addr=0x100, old rdata never appears in IF/ID.
3. br_sel=10, jalr_target=0x203, fetch outstanding (ack 3 cycles late) -> imem_addr holds the old value until ack, that rdata is discarded, next request is at 0x200.
4. stall=1 for 3 cycles with ack during the stall -> IF/ID unchanged, imem_req=0 after capture; on stall drop IF/ID gets the buffered instruction; no instruction is lost or duplicated.
5. stall drops while br_sel=01, br_target=0x40, in HOLD -> skid discarded, flush pulses, fetch at 0x40.
6. pc=0xFFFF_FFFC with ack -> next imem_addr=0x0. Separately, assert rst mid-fetch -> all outputs return to reset values asynchronously; after release, fetch restarts at RESET_PC.
